// File: rtl/wb_master_bridge.sv
// Wishbone classic-cycle master: turns single CPU read/write requests into bus cycles,
// with err/rty handling and bounded retry. Define WB_TIMEOUT_EN to add a VALID-state watchdog.
module wb_master_bridge #(
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 32,
    parameter int TAG_BIT   = 16,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_adr_i,
    input  logic [DATA_W-1:0]   cpu_dat_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic                cpu_busy_o,
    output logic                cpu_done_o,
    output logic                cpu_err_o,
    output logic [DATA_W-1:0]   cpu_dat_o,
    output logic [ADDR_W-1:0]   adr_o,
    output logic [DATA_W-1:0]   dat_o,
    input  logic [DATA_W-1:0]   dat_i,
    output logic [DATA_W/8-1:0] sel_o,
    output logic                we_o,
    output logic                stb_o,
    output logic                cyc_o,
    output logic                tag_o,
    input  logic                ack_i,
    input  logic                err_i,
    input  logic                rty_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    if ((DATA_W % 8) != 0 || MAX_RETRY < 0 || MAX_RETRY > 15 || TIMEOUT < 1
        || TAG_BIT < 0 || TAG_BIT >= ADDR_W) begin : g_bad_params
        $error("wb_master_bridge: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VALID   = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic [SEL_W-1:0]    sel_q;
    logic                we_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [3:0]          retry_cnt;
    logic                err_flag;

`ifdef WB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0]    tmo_cnt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            retry_cnt <= '0;
            err_flag  <= 1'b0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i) begin
                        adr_q <= cpu_adr_i;
                        dat_q <= cpu_dat_i;
                        sel_q <= cpu_sel_i;
                        we_q  <= cpu_we_i;
                        state <= VALID;
                    end
                end
                VALID: begin
                    // Termination priority is ack > err > rty.
                    if (ack_i) begin
                        if (!we_q) begin
                            rdata_q <= dat_i;
                        end
                        state <= RESP;
`ifdef WB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else if (err_i) begin
                        err_flag <= 1'b1;
                        state    <= RESP;
`ifdef WB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end else if (rty_i) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            state     <= BACKOFF;
                        end else begin
                            err_flag <= 1'b1;
                            state    <= RESP;
                        end
`ifdef WB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
`ifdef WB_TIMEOUT_EN
                        // The last counted VALID cycle without termination aborts the cycle.
                        if (tmo_cnt == TMO_LAST) begin
                            err_flag <= 1'b1;
                            tmo_cnt  <= '0;
                            state    <= RESP;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
`else
                        state <= VALID;
`endif
                    end
                end
                BACKOFF: begin
                    state <= VALID;
                end
                RESP: begin
                    retry_cnt <= '0;
                    err_flag  <= 1'b0;
`ifdef WB_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus handshake and CPU status are straight decodes of the state register.
    assign stb_o      = (state == VALID);
    assign cyc_o      = (state == VALID);
    assign cpu_busy_o = (state != IDLE);
    assign cpu_done_o = (state == RESP);
    assign cpu_err_o  = (state == RESP) && err_flag;

    assign adr_o     = adr_q;
    assign dat_o     = dat_q;
    assign sel_o     = sel_q;
    assign we_o      = we_q;
    assign tag_o     = adr_q[TAG_BIT];
    assign cpu_dat_o = rdata_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever cpu_done_o is seen.
module tb_wb_master_bridge;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_adr = '0;
    logic [DATA_W-1:0] cpu_dat = '0;
    logic [SEL_W-1:0]  cpu_sel = '0;
    logic              cpu_busy, cpu_done, cpu_err;
    logic [DATA_W-1:0] cpu_rdat;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] rdat = '0;
    logic [SEL_W-1:0]  sel;
    logic              we, stb, cyc, tag;
    logic              ack = 1'b0, err = 1'b0, rty = 1'b0;

    always #5 clk = ~clk;

    wb_master_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_BIT(16), .MAX_RETRY(3), .TIMEOUT(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_adr_i(cpu_adr),
        .cpu_dat_i(cpu_dat), .cpu_sel_i(cpu_sel),
        .cpu_busy_o(cpu_busy), .cpu_done_o(cpu_done), .cpu_err_o(cpu_err),
        .cpu_dat_o(cpu_rdat),
        .adr_o(adr), .dat_o(wdat), .dat_i(rdat), .sel_o(sel), .we_o(we),
        .stb_o(stb), .cyc_o(cyc), .tag_o(tag),
        .ack_i(ack), .err_i(err), .rty_i(rty)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       mon_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && cpu_done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no response");
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_err", 64'(cpu_err), 64'(mon_e.err));
                check("resp_dat", 64'(cpu_rdat), 64'(mon_e.dat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge, then scrambles CPU inputs to prove the capture holds.
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s);
        cpu_req = 1'b1;
        cpu_we  = w;
        cpu_adr = a;
        cpu_dat = d;
        cpu_sel = s;
        step();
        cpu_req = 1'b0;
        cpu_we  = ~w;
        cpu_adr = ~a;
        cpu_dat = ~d;
        cpu_sel = ~s;
    endtask

    task automatic respond(input int dly, input logic a, input logic e, input logic r,
                           input logic [DATA_W-1:0] d);
        repeat (dly) step();
        ack  = a;
        err  = e;
        rty  = r;
        rdat = d;
        step();
        ack = 1'b0;
        err = 1'b0;
        rty = 1'b0;
        rdat = 32'h0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (cpu_busy && n < 20) begin
            step();
            n++;
        end
        if (cpu_busy) begin
            total++;
            bad++;
            $display("FAIL %s: got busy=1 after %0d cycles expected idle", name, n);
        end
    endtask

    initial begin
        #1;
        check("rst_stb", 64'(stb), 64'd0);
        check("rst_cyc", 64'(cyc), 64'd0);
        check("rst_busy", 64'(cpu_busy), 64'd0);
        check("rst_done", 64'(cpu_done), 64'd0);
        check("rst_outs", {cpu_rdat, 6'd0, adr}, 64'd0);
        check("rst_ctl", {60'd0, we, tag, cpu_err, |sel}, 64'd0);
        step();
        step();
        rst = 1'b0;

        // Asynchronous reset while in VALID
        issue(1'b0, 26'h80, 32'h0, 4'hF);
        check("pre_rst_stb", 64'(stb), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_stb", 64'(stb), 64'd0);
        check("async_rst_cyc", 64'(cyc), 64'd0);
        check("async_rst_busy", 64'(cpu_busy), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", 64'(cpu_busy), 64'd0);

        // Read, ack two cycles after stb rises
        model_rdata = 32'hDEADBEEF;
        exp_q.push_back('{err: 1'b0, dat: model_rdata});
        issue(1'b0, 26'h00010, 32'h0, 4'hF);
        check("rd_adr", 64'(adr), 64'h10);
        check("rd_tag", 64'(tag), 64'd0);
        check("rd_we", 64'(we), 64'd0);
        respond(1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        wait_idle("rd_idle");

        // Write with byte select
        exp_q.push_back('{err: 1'b0, dat: model_rdata});
        issue(1'b1, 26'h10004, 32'h000000A5, 4'b0001);
        check("wr_tag", 64'(tag), 64'd1);
        check("wr_fields", {31'd0, we, wdat}, {31'd0, 1'b1, 32'h000000A5});
        step();
        step();
        check("wr_hold", {we, sel, wdat, 1'b0, adr}, {1'b1, 4'b0001, 32'h000000A5, 1'b0, 26'h10004});
        respond(0, 1'b1, 1'b0, 1'b0, 32'h55555555);
        wait_idle("wr_idle");
        check("wr_rdata_kept", 64'(cpu_rdat), 64'hDEADBEEF);

        // Two retries then ack
        model_rdata = 32'hCAFEF00D;
        exp_q.push_back('{err: 1'b0, dat: model_rdata});
        issue(1'b0, 26'h20, 32'h0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            respond(0, 1'b0, 1'b0, 1'b1, 32'h0);
            check("rty_gap", 64'(stb), 64'd0);
            step();
            check("rty_reissue", 64'(stb), 64'd1);
        end
        respond(0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
        wait_idle("rty_idle");

        // Four retries exhaust MAX_RETRY=3
        exp_q.push_back('{err: 1'b1, dat: model_rdata});
        issue(1'b0, 26'h30, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            respond(0, 1'b0, 1'b0, 1'b1, 32'h0);
            check("rty4_gap", 64'(stb), 64'd0);
            step();
        end
        respond(0, 1'b0, 1'b0, 1'b1, 32'h11111111);
        check("rty4_done", 64'(cpu_done), 64'd1);
        wait_idle("rty4_idle");

        // All terminations at once resolve as ack
        model_rdata = 32'h12345678;
        exp_q.push_back('{err: 1'b0, dat: model_rdata});
        issue(1'b0, 26'h40, 32'h0, 4'hF);
        respond(0, 1'b1, 1'b1, 1'b1, 32'h12345678);
        wait_idle("all_idle");

        // err alone leaves read data untouched
        exp_q.push_back('{err: 1'b1, dat: model_rdata});
        issue(1'b0, 26'h50, 32'h0, 4'hF);
        respond(0, 1'b0, 1'b1, 1'b0, 32'hBAD0BAD0);
        wait_idle("err_idle");
        check("err_rdata_kept", 64'(cpu_rdat), 64'(model_rdata));

        // Request while busy is dropped
        model_rdata = 32'h0F0F0F0F;
        exp_q.push_back('{err: 1'b0, dat: model_rdata});
        issue(1'b0, 26'h60, 32'h0, 4'hF);
        cpu_req = 1'b1;
        cpu_adr = 26'h70;
        step();
        check("busy_adr_held", 64'(adr), 64'h60);
        cpu_req = 1'b0;
        respond(0, 1'b1, 1'b0, 1'b0, 32'h0F0F0F0F);
        wait_idle("busy_idle");
        step();
        check("no_queued_req", 64'(cpu_busy), 64'd0);

        // Terminations while idle are ignored
        ack = 1'b1;
        err = 1'b1;
        rty = 1'b1;
        step();
        step();
        ack = 1'b0;
        err = 1'b0;
        rty = 1'b0;
        check("idle_term_ignored", {cpu_busy, cpu_rdat}, {1'b0, model_rdata});

`ifdef WB_TIMEOUT_EN
        begin
            int stb_cycles;
            exp_q.push_back('{err: 1'b1, dat: model_rdata});
            issue(1'b0, 26'h90, 32'h0, 4'hF);
            stb_cycles = 0;
            while (stb && stb_cycles < 50) begin
                stb_cycles++;
                step();
            end
            check("tmo_stb_cycles", 64'(stb_cycles), 64'd8);
            wait_idle("tmo_idle");
            model_rdata = 32'h600DF00D;
            exp_q.push_back('{err: 1'b0, dat: model_rdata});
            issue(1'b0, 26'hA0, 32'h0, 4'hF);
            respond(0, 1'b1, 1'b0, 1'b0, 32'h600DF00D);
            wait_idle("tmo_next_idle");
        end
`endif

        step();
        step();
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
Parametrised Wishbone classic-cycle master that turns single read/write requests from the ARM-side core into Wishbone bus cycles. It replaces the fixed 26/32-bit, read-mostly master with the following:
- configurable address and data widths;
- full write support with byte selects;
- err/rty termination handling with bounded retry;
- a latched read-data return path.
It sits between the CPU request port and the Wishbone interconnect that serves memory and the SSP.

Parameters:
ADDR_W, 26, address width in bits.
DATA_W, 32, data width in bits; must be a multiple of 8.
TAG_BIT, 16, address bit that drives tag_o (0 = memory, 1 = SSP).
MAX_RETRY, 3, number of re-issues allowed after rty_i before the request is reported as an error (0..15).
TIMEOUT, 255, cycles spent in VALID without termination before abort (used only with WB_TIMEOUT_EN).

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  reset; asynchronous, active-high.
cpu_req_i  in  1  request strobe; sampled only in IDLE.
cpu_we_i  in  1  1 = write, 0 = read.
cpu_adr_i  in  ADDR_W  request address.
cpu_dat_i  in  DATA_W  write data.
cpu_sel_i  in  DATA_W/8  byte enables.
cpu_busy_o  out  1  high while a request is in flight (state != IDLE).
cpu_done_o  out  1  one-cycle pulse on completion (success or error).
cpu_err_o  out  1  valid with cpu_done_o; 1 = err, retry exhaustion or timeout.
cpu_dat_o  out  DATA_W  latched read data.
adr_o  out  ADDR_W  Wishbone address.
dat_o  out  DATA_W  Wishbone write data.
dat_i  in  DATA_W  Wishbone read data.
sel_o  out  DATA_W/8  Wishbone byte selects.
we_o  out  1  Wishbone write enable.
stb_o  out  1  Wishbone strobe.
cyc_o  out  1  Wishbone cycle.
tag_o  out  1  copy of the latched address bit TAG_BIT.
ack_i  in  1  normal termination.
err_i  in  1  error termination.
rty_i  in  1  retry termination.

Behaviour:
- Reset values: all outputs 0; state = IDLE; retry count = 0; timeout count = 0. Reset mid-cycle drops stb_o/cyc_o immediately, because reset is asynchronous.
- The request is captured into internal registers on the clock edge where state = IDLE and cpu_req_i = 1. The captured fields are adr, dat, sel, we.
- adr_o, dat_o, sel_o, we_o and tag_o are driven from these registers and stay stable for the whole bus cycle. CPU inputs may change after the capture.
- States:
  - IDLE: capture on cpu_req_i, then go to VALID. Otherwise stay in IDLE.
  - VALID: stb_o = cyc_o = 1. Termination inputs are sampled each edge with priority ack_i > err_i > rty_i:
    - ack_i: go to RESP; latch dat_i into cpu_dat_o if this is a read.
    - err_i: go to RESP with the error flag set.
    - rty_i with retry count < MAX_RETRY: increment the count, go to BACKOFF.
    - rty_i with retry count = MAX_RETRY: go to RESP with the error flag set.
    - No termination input: stay in VALID.
  - BACKOFF: stb_o = cyc_o = 0 for exactly one cycle, then back to VALID with the same captured request.
  - RESP: stb_o = cyc_o = 0; cpu_done_o = 1 and cpu_err_o = error flag for this one cycle. Then go to IDLE and clear the retry count, timeout count and error flag.
- stb_o, cyc_o, cpu_busy_o and cpu_done_o are pure decodes of the state register; they are glitch-free.
- Minimum latency: capture at edge N, stb_o high in cycle N+1. If ack_i is seen at edge N+1, cpu_done_o is high in cycle N+2. The next capture is possible at edge N+3.
- cpu_dat_o holds its value until the next successful read; it is unchanged by writes and by errored reads.
- A cpu_req_i asserted while busy is ignored; it is not queued.
- Termination inputs outside VALID are ignored.

Optional Feature:
Macro WB_TIMEOUT_EN.
- Defined: a counter increments on every cycle spent in VALID and is reset on entry to BACKOFF or RESP. When it reaches TIMEOUT with no termination, the block goes to RESP with the error flag set. An ack_i arriving on that same edge still wins.
- Undefined: no counter is built, and VALID waits indefinitely.

Test Plan:
1. Reset: assert rst_i asynchronously while the block is in VALID -> stb_o/cyc_o/cpu_busy_o go to 0 without waiting for a clock edge; after release the block is in IDLE.
2. Read: cpu_adr_i=0x00010, we=0, slave acks 2 cycles after stb_o rises with dat_i=0xDEADBEEF -> tag_o=0; cpu_done_o pulses once with cpu_err_o=0; cpu_dat_o=0xDEADBEEF.
3. Write: cpu_adr_i=0x10004, dat=0x000000A5, sel=4'b0001 -> tag_o=1, we_o=1, dat_o=0x000000A5, sel_o=0001 held until ack; cpu_dat_o unchanged.
4. Retry: slave returns rty_i twice, then ack, with MAX_RETRY=3 -> stb_o shows two one-cycle gaps; done is reported with err=0. With 4 retries: done with err=1 after the 4th rty.
5. Simultaneous ack_i=err_i=rty_i=1 -> treated as ack, err=0. err_i alone -> done with err=1 and cpu_dat_o unchanged.
6. With WB_TIMEOUT_EN, TIMEOUT=8 and a silent slave -> stb_o high for exactly 8 cycles, then done with err=1; a new request is accepted afterwards.
